// File: rtl/fc8_interrupt_controller_pkg.sv
// Shared constants and types for the FC8 interrupt controller: SFR offsets,
// INT_CTRL bit positions, source indices and the NMI pulse FSM states.
package fc8_interrupt_controller_pkg;

  localparam logic [2:0] INT_ENABLE_OFS    = 3'd0;
  localparam logic [2:0] INT_STATUS_OFS    = 3'd1;
  localparam logic [2:0] INT_PENDING_OFS   = 3'd2;
  localparam logic [2:0] INT_CTRL_OFS      = 3'd3;
  localparam logic [2:0] INT_ACTIVE_ID_OFS = 3'd4;

  localparam int NMI_EN_BIT        = 0;
  localparam int IRQ_MASTER_EN_BIT = 1;

  localparam int INT_SRC_VBLANK = 0;
  localparam int INT_SRC_TIMER  = 1;

  typedef enum logic {
    NMI_IDLE  = 1'b0,
    NMI_PULSE = 1'b1
  } nmi_state_e;

  // Bits at or above num_src are unimplemented: they read 0 and ignore writes.
  function automatic logic [7:0] src_mask(input int num_src);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < num_src) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fc8_int_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module fc8_int_prio_enc (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scanning downward lets the lowest set bit overwrite the higher ones.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/fc8_interrupt_controller.sv
// FC8 interrupt controller: captures source edges into INT_STATUS, drives a
// prioritised level IRQ and a fixed-length NMI pulse for the VBLANK source.
module fc8_interrupt_controller
  import fc8_interrupt_controller_pkg::*;
#(
  parameter int NUM_SRC       = 8,
  parameter int NMI_PULSE_LEN = 4
) (
  input  logic               master_clk,
  input  logic               master_rst_n,
  input  logic [NUM_SRC-1:0] src_evt,
  input  logic               sfr_sel,
  input  logic               sfr_we,
  input  logic [2:0]         sfr_addr,
  input  logic [7:0]         sfr_wdata,
  output logic [7:0]         sfr_rdata,
  input  logic               cpu_irq_ack,
  output logic               cpu_irq_req,
  output logic               cpu_nmi_req
);

  localparam logic [7:0] SRC_MASK = src_mask(NUM_SRC);
  localparam int CNT_W = (NMI_PULSE_LEN > 1) ? $clog2(NMI_PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NMI_PULSE_LEN - 1);

  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [7:0]         enable_q, enable_d;
  logic [7:0]         status_q, status_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [7:0]         active_id_q, active_id_d;
  logic               irq_req_q, irq_req_d;
  logic               nmi_req_q, nmi_req_d;
  logic               nmi_cond_prev_q, nmi_cond_prev_d;
  nmi_state_e         nmi_state_q, nmi_state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic       wr_en;
  logic [7:0] evt_rise;
  logic [7:0] w1c;
  logic       nmi_en;
  logic       nmi_cond;
  logic [7:0] irq_pend;
  logic       pend_valid;
  logic [2:0] pend_id;

  assign wr_en    = sfr_sel & sfr_we;
  assign evt_rise = 8'(src_evt & ~src_prev_q);
  assign w1c      = (wr_en && sfr_addr == INT_STATUS_OFS) ? (sfr_wdata & SRC_MASK) : '0;
  assign nmi_en   = ctrl_q[NMI_EN_BIT];
  assign nmi_cond = nmi_en & status_q[INT_SRC_VBLANK];
  // With NMI routing on, VBLANK is owned by the NMI path and hidden from IRQ.
  assign irq_pend = status_q & enable_q & ~{7'b0, nmi_en};

  fc8_int_prio_enc u_prio_enc (
    .req   (irq_pend),
    .valid (pend_valid),
    .id    (pend_id)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    src_prev_d  = src_evt;
    enable_d    = enable_q;
    ctrl_d      = ctrl_q;
    active_id_d = active_id_q;
    // Applying the set after the clear makes a same-cycle event win.
    status_d    = (status_q & ~w1c) | evt_rise;

    if (wr_en) begin
      case (sfr_addr)
        INT_ENABLE_OFS: enable_d = sfr_wdata & SRC_MASK;
        INT_CTRL_OFS:   ctrl_d   = sfr_wdata[1:0];
        default: ;
      endcase
    end

    if (cpu_irq_ack) begin
      active_id_d = pend_valid ? {1'b1, 4'b0000, pend_id} : 8'h00;
    end

    irq_req_d = ctrl_q[IRQ_MASTER_EN_BIT] & (|irq_pend);
  end

  always_comb begin
    nmi_state_d     = nmi_state_q;
    cnt_d           = cnt_q;
    nmi_req_d       = nmi_req_q;
    nmi_cond_prev_d = nmi_cond;

    case (nmi_state_q)
      NMI_IDLE: begin
        if (nmi_cond && !nmi_cond_prev_q) begin
          nmi_state_d = NMI_PULSE;
          cnt_d       = CNT_LOAD;
          nmi_req_d   = 1'b1;
        end
      end
      NMI_PULSE: begin
        // Runs to completion regardless of nmi_cond; new rises here are dropped.
        if (cnt_q == '0) begin
          nmi_state_d = NMI_IDLE;
          nmi_req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        nmi_state_d = NMI_IDLE;
        nmi_req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge master_clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      src_prev_q      <= '0;
      enable_q        <= '0;
      status_q        <= '0;
      ctrl_q          <= '0;
      active_id_q     <= '0;
      irq_req_q       <= 1'b0;
      nmi_req_q       <= 1'b0;
      nmi_cond_prev_q <= 1'b0;
      nmi_state_q     <= NMI_IDLE;
      cnt_q           <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      src_prev_q      <= src_prev_d;
      enable_q        <= enable_d;
      status_q        <= status_d;
      ctrl_q          <= ctrl_d;
      active_id_q     <= active_id_d;
      irq_req_q       <= irq_req_d;
      nmi_req_q       <= nmi_req_d;
      nmi_cond_prev_q <= nmi_cond_prev_d;
      nmi_state_q     <= nmi_state_d;
      cnt_q           <= cnt_d;
    end
  end

  always_comb begin
    sfr_rdata = 8'h00;
    case (sfr_addr)
      INT_ENABLE_OFS:    sfr_rdata = enable_q;
      INT_STATUS_OFS:    sfr_rdata = status_q;
      INT_PENDING_OFS:   sfr_rdata = irq_pend;
      INT_CTRL_OFS:      sfr_rdata = {6'b000000, ctrl_q};
      INT_ACTIVE_ID_OFS: sfr_rdata = active_id_q;
      default:           sfr_rdata = 8'h00;
    endcase
  end

  assign cpu_irq_req = irq_req_q;
  assign cpu_nmi_req = nmi_req_q;

endmodule

// File: tb/tb_fc8_interrupt_controller.sv
// Scenario-driven bench for fc8_interrupt_controller; expected values are
// queued on a scoreboard as stimulus is applied and popped when observed.
module tb_fc8_interrupt_controller;

  logic       master_clk;
  logic       master_rst_n;
  logic [7:0] src_evt;
  logic       sfr_sel;
  logic       sfr_we;
  logic [2:0] sfr_addr;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;
  logic       cpu_irq_ack;
  logic       cpu_irq_req;
  logic       cpu_nmi_req;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  fc8_interrupt_controller #(
    .NUM_SRC       (8),
    .NMI_PULSE_LEN (4)
  ) dut (
    .master_clk   (master_clk),
    .master_rst_n (master_rst_n),
    .src_evt      (src_evt),
    .sfr_sel      (sfr_sel),
    .sfr_we       (sfr_we),
    .sfr_addr     (sfr_addr),
    .sfr_wdata    (sfr_wdata),
    .sfr_rdata    (sfr_rdata),
    .cpu_irq_ack  (cpu_irq_ack),
    .cpu_irq_req  (cpu_irq_req),
    .cpu_nmi_req  (cpu_nmi_req)
  );

  initial master_clk = 1'b0;
  always #10 master_clk = ~master_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge, well clear of it.
  task automatic tick();
    @(posedge master_clk);
    #1;
  endtask

  task automatic sb_push(input string name, input logic [7:0] exp);
    exp_t x;
    x.name = name;
    x.exp  = exp;
    sb_q.push_back(x);
  endtask

  task automatic sfr_write(input logic [2:0] addr, input logic [7:0] data);
    sfr_sel   = 1'b1;
    sfr_we    = 1'b1;
    sfr_addr  = addr;
    sfr_wdata = data;
    tick();
    sfr_sel   = 1'b0;
    sfr_we    = 1'b0;
  endtask

  task automatic sfr_read(input logic [2:0] addr, output logic [7:0] data);
    sfr_sel  = 1'b1;
    sfr_we   = 1'b0;
    sfr_addr = addr;
    #1;
    data     = sfr_rdata;
    sfr_sel  = 1'b0;
  endtask

  task automatic irq_ack();
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    master_rst_n = 1'b0;
    src_evt = '0; sfr_sel = 1'b0; sfr_we = 1'b0; sfr_addr = '0; sfr_wdata = '0; cpu_irq_ack = 1'b0;
    #25 master_rst_n = 1'b1;
    tick();
    for (int a = 0; a < 5; a++) begin
      sb_push($sformatf("reset_reg%0d", a), 8'h00);
      sfr_read(3'(a), got);
      e = sb_q.pop_front(); n_checks++;
      if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    end
    sb_push("reset_irq_nmi", 8'h00);
    got = {6'b0, cpu_nmi_req, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
  endtask

  task automatic test_timer_irq();
    logic [7:0] got;
    sfr_write(3'd0, 8'h02);
    sfr_write(3'd3, 8'h02);
    src_evt[1] = 1'b1;
    sb_push("timer_status", 8'h02);
    sb_push("timer_irq_at_E", 8'h00);
    tick();
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    got = {7'b0, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("timer_irq_at_E1", 8'h01);
    tick();
    got = {7'b0, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("timer_active_id", 8'h81);
    sb_push("timer_status_after_ack", 8'h02);
    irq_ack();
    sfr_read(3'd4, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("timer_irq_at_w1c_edge", 8'h01);
    sb_push("timer_irq_after_w1c", 8'h00);
    sfr_write(3'd1, 8'h02);
    got = {7'b0, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    tick();
    got = {7'b0, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    src_evt[1] = 1'b0;
    tick();
  endtask

  task automatic test_vblank_nmi();
    logic [7:0] got;
    int         highs;
    int         first;
    logic       irq_seen;
    sfr_write(3'd3, 8'h03);
    sfr_write(3'd0, 8'h03);
    src_evt[0] = 1'b1;
    sb_push("nmi_pending", 8'h00);
    sb_push("nmi_first_cycle", 8'h01);
    sb_push("nmi_len", 8'h04);
    sb_push("nmi_no_irq", 8'h00);
    highs = 0; first = -1; irq_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        sfr_read(3'd2, got);
        e = sb_q.pop_front(); n_checks++;
        if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
      end
      if (cpu_nmi_req) begin highs++; if (first < 0) first = i; end
      if (cpu_irq_req) irq_seen = 1'b1;
    end
    got = 8'(first);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    got = 8'(highs);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    got = {7'b0, irq_seen};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end

    // Re-arm: clear STATUS[0], drop the level, then raise it again.
    sfr_write(3'd1, 8'h01);
    src_evt[0] = 1'b0;
    tick();
    src_evt[0] = 1'b1;
    sb_push("nmi_len_with_clear", 8'h04);
    sb_push("nmi_status_cleared", 8'h00);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      sfr_sel   = (i == 2);
      sfr_we    = (i == 2);
      sfr_addr  = 3'd1;
      sfr_wdata = 8'h01;
      tick();
      if (cpu_nmi_req) highs++;
    end
    sfr_sel = 1'b0; sfr_we = 1'b0;
    got = 8'(highs);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    src_evt[0] = 1'b0;
    tick();
  endtask

  task automatic test_priority_mask();
    logic [7:0] got;
    sfr_write(3'd1, 8'hFF);
    sfr_write(3'd0, 8'h0C);
    sfr_write(3'd3, 8'h02);
    src_evt = 8'h2C;
    sb_push("prio_status", 8'h2C);
    sb_push("prio_pending", 8'h0C);
    tick();
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd2, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("prio_irq", 8'h01);
    tick();
    got = {7'b0, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("prio_active_id", 8'h82);
    irq_ack();
    sfr_read(3'd4, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("mask_irq_off", 8'h00);
    sb_push("mask_status_kept", 8'h2C);
    sfr_write(3'd3, 8'h00);
    tick();
    got = {7'b0, cpu_irq_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    src_evt = 8'h00;
    sfr_write(3'd1, 8'hFF);
  endtask

  task automatic test_collisions();
    logic [7:0] got;
    src_evt[1] = 1'b1;
    sb_push("collide_set_wins", 8'h02);
    sfr_write(3'd1, 8'h02);
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("spurious_ack_id", 8'h00);
    irq_ack();
    sfr_read(3'd4, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("addr5_reads_zero", 8'h00);
    sb_push("addr5_enable_kept", 8'h0C);
    sb_push("addr5_status_kept", 8'h02);
    sfr_write(3'd5, 8'hFF);
    sfr_read(3'd5, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd0, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sb_push("ctrl_upper_bits_zero", 8'h03);
    sfr_write(3'd3, 8'hFF);
    sfr_read(3'd3, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_write(3'd3, 8'h00);
    src_evt = 8'h00;
    tick();
  endtask

  task automatic test_mid_pulse_reset();
    logic [7:0] got;
    sfr_write(3'd1, 8'hFF);
    sfr_write(3'd3, 8'h01);
    src_evt[0] = 1'b1;
    tick();
    tick();
    sb_push("pulse_before_reset", 8'h01);
    sb_push("nmi_async_reset", 8'h00);
    tick();
    got = {7'b0, cpu_nmi_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    #3 master_rst_n = 1'b0;
    #1;
    got = {7'b0, cpu_nmi_req};
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    #5 master_rst_n = 1'b1;
    sb_push("status_before_first_edge", 8'h00);
    sb_push("status_level_at_release", 8'h01);
    sb_push("ctrl_after_reset", 8'h00);
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    tick();
    sfr_read(3'd1, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    sfr_read(3'd3, got);
    e = sb_q.pop_front(); n_checks++;
    if (got !== e.exp) begin n_fail++; $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, got, e.exp); end
    src_evt = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_vblank_nmi();
    test_priority_mask();
    test_collisions();
    test_mid_pulse_reset();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
